// File: rtl/lsu_mem_arbiter.sv
// Two-lane load/store arbiter onto a single-port RAM. Conflicts are served over
// two cycles with a stall; both lanes' load data are then returned together.
module lsu_mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] l0_wr_addr,
    input  logic [DATA_W-1:0] l0_wr_data,
    input  logic              l0_wr_en,
    input  logic [ADDR_W-1:0] l0_rd_addr,
    input  logic              l0_rd_en,
    output logic [DATA_W-1:0] l0_rd_data,
    input  logic [ADDR_W-1:0] l1_wr_addr,
    input  logic [DATA_W-1:0] l1_wr_data,
    input  logic              l1_wr_en,
    input  logic [ADDR_W-1:0] l1_rd_addr,
    input  logic              l1_rd_en,
    output logic [DATA_W-1:0] l1_rd_data,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wr_data,
    output logic              ram_wr_en,
    output logic              ram_rd_en,
    input  logic [DATA_W-1:0] ram_rd_data,
    output logic              mem_stall
);

    typedef enum logic {IDLE, SECOND} state_t;

    state_t            state;
    logic              prio;
    logic              served;
    logic              rd_v;
    logic              rd_ln;
    logic              hold_v;
    logic              hold_ln;
    logic [DATA_W-1:0] hold_data;

    logic              act0, act1;
    logic              gnt_v, gnt_ln;
    logic              g_we, g_re;
    logic [ADDR_W-1:0] g_wa, g_ra;
    logic [DATA_W-1:0] g_wd;

    assign act0 = l0_wr_en | l0_rd_en;
    assign act1 = l1_wr_en | l1_rd_en;

    always_comb begin
        gnt_v     = 1'b0;
        gnt_ln    = 1'b0;
        mem_stall = 1'b0;
        if (!rst) begin
            case (state)
                IDLE: begin
                    if (act0 && act1) begin
                        gnt_v     = 1'b1;
                        gnt_ln    = prio;
                        mem_stall = 1'b1;
                    end else if (act0) begin
                        gnt_v  = 1'b1;
                        gnt_ln = 1'b0;
                    end else if (act1) begin
                        gnt_v  = 1'b1;
                        gnt_ln = 1'b1;
                    end
                end
                SECOND: begin
                    gnt_ln = ~served;
                    gnt_v  = served ? act0 : act1;
                end
                default: ;
            endcase
        end
    end

    assign g_we = gnt_ln ? l1_wr_en   : l0_wr_en;
    assign g_re = gnt_ln ? l1_rd_en   : l0_rd_en;
    assign g_wa = gnt_ln ? l1_wr_addr : l0_wr_addr;
    assign g_ra = gnt_ln ? l1_rd_addr : l0_rd_addr;
    assign g_wd = gnt_ln ? l1_wr_data : l0_wr_data;

    // A store wins over a load requested on the same lane in the same cycle.
    assign ram_wr_en   = gnt_v & g_we;
    assign ram_rd_en   = gnt_v & ~g_we & g_re;
    assign ram_addr    = !gnt_v ? '0 : (g_we ? g_wa : g_ra);
    assign ram_wr_data = ram_wr_en ? g_wd : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            prio      <= 1'b0;
            served    <= 1'b0;
            rd_v      <= 1'b0;
            rd_ln     <= 1'b0;
            hold_v    <= 1'b0;
            hold_ln   <= 1'b0;
            hold_data <= '0;
        end else begin
            rd_v   <= ram_rd_en;
            rd_ln  <= gnt_ln;
            hold_v <= 1'b0;
            case (state)
                IDLE: begin
                    if (mem_stall) begin
                        served <= prio;
                        state  <= SECOND;
                    end
                end
                SECOND: begin
                    prio  <= ~served;
                    state <= IDLE;
                    // The first lane's load data arrives now; park it one cycle so
                    // it lines up with the second lane's data.
                    if (rd_v && (rd_ln == served)) begin
                        hold_v    <= 1'b1;
                        hold_ln   <= served;
                        hold_data <= ram_rd_data;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign l0_rd_data = (hold_v && !hold_ln) ? hold_data :
                        (rd_v && !rd_ln)     ? ram_rd_data : '0;
    assign l1_rd_data = (hold_v && hold_ln)  ? hold_data :
                        (rd_v && rd_ln)      ? ram_rd_data : '0;

endmodule

// File: tb/tb_lsu_mem_arbiter.sv
// Directed bench: per-cycle expectations go into a queue, a negedge monitor
// pops and compares them against the arbiter outputs.
module tb_lsu_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] l0_wr_addr = '0, l0_wr_data = '0, l0_rd_addr = '0;
    logic [31:0] l1_wr_addr = '0, l1_wr_data = '0, l1_rd_addr = '0;
    logic        l0_wr_en = 1'b0, l0_rd_en = 1'b0, l1_wr_en = 1'b0, l1_rd_en = 1'b0;
    logic [31:0] l0_rd_data, l1_rd_data;
    logic [31:0] ram_addr, ram_wr_data;
    logic        ram_wr_en, ram_rd_en, mem_stall;
    logic [31:0] ram_rd_data = '0;

    logic [31:0] mem [0:255];

    typedef struct {
        int          cyc;
        int          sel;
        logic [31:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   cycle = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   tag = 0;

    lsu_mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .l0_wr_addr(l0_wr_addr), .l0_wr_data(l0_wr_data), .l0_wr_en(l0_wr_en),
        .l0_rd_addr(l0_rd_addr), .l0_rd_en(l0_rd_en), .l0_rd_data(l0_rd_data),
        .l1_wr_addr(l1_wr_addr), .l1_wr_data(l1_wr_data), .l1_wr_en(l1_wr_en),
        .l1_rd_addr(l1_rd_addr), .l1_rd_en(l1_rd_en), .l1_rd_data(l1_rd_data),
        .ram_addr(ram_addr), .ram_wr_data(ram_wr_data), .ram_wr_en(ram_wr_en),
        .ram_rd_en(ram_rd_en), .ram_rd_data(ram_rd_data), .mem_stall(mem_stall)
    );

    always #5 clk = ~clk;

    // Synchronous single-port RAM: read data appears one cycle after ram_rd_en.
    always @(posedge clk) begin
        if (ram_wr_en) mem[ram_addr[7:0]] <= ram_wr_data;
        if (ram_rd_en) ram_rd_data <= mem[ram_addr[7:0]];
    end

    always @(posedge clk) cycle <= cycle + 1;

    function automatic logic [31:0] observe(input int sel);
        case (sel)
            0: return ram_addr;
            1: return ram_wr_data;
            2: return {31'd0, ram_wr_en};
            3: return {31'd0, ram_rd_en};
            4: return {31'd0, mem_stall};
            5: return l0_rd_data;
            6: return l1_rd_data;
            default: return 32'hxxxx_xxxx;
        endcase
    endfunction

    function automatic string sig_name(input int sel);
        case (sel)
            0: return "ram_addr";
            1: return "ram_wr_data";
            2: return "ram_wr_en";
            3: return "ram_rd_en";
            4: return "mem_stall";
            5: return "l0_rd_data";
            6: return "l1_rd_data";
            default: return "unknown";
        endcase
    endfunction

    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].cyc <= cycle) begin
            exp_t e;
            logic [31:0] got;
            e = exp_q.pop_front();
            n_checks++;
            if (e.cyc < cycle) begin
                n_fail++;
                $display("FAIL stale_%s step %0d: not checked in its cycle, required %h",
                         sig_name(e.sel), e.cyc, e.val);
            end else begin
                got = observe(e.sel);
                if (got !== e.val) begin
                    n_fail++;
                    $display("FAIL %s step %0d: got %h required %h",
                             sig_name(e.sel), e.cyc, got, e.val);
                end
            end
        end
    end

    task automatic drive(input logic r,
                         input logic we0, input logic re0, input logic [31:0] wa0,
                         input logic [31:0] wd0, input logic [31:0] ra0,
                         input logic we1, input logic re1, input logic [31:0] wa1,
                         input logic [31:0] wd1, input logic [31:0] ra1);
        @(posedge clk);
        #1;
        rst = r;
        l0_wr_en = we0; l0_rd_en = re0; l0_wr_addr = wa0; l0_wr_data = wd0; l0_rd_addr = ra0;
        l1_wr_en = we1; l1_rd_en = re1; l1_wr_addr = wa1; l1_wr_data = wd1; l1_rd_addr = ra1;
    endtask

    task automatic expect_out(input logic [31:0] addr, input logic [31:0] wd,
                              input logic we, input logic re, input logic st,
                              input logic [31:0] r0, input logic [31:0] r1);
        exp_q.push_back('{cycle, 0, addr});
        exp_q.push_back('{cycle, 1, wd});
        exp_q.push_back('{cycle, 2, {31'd0, we}});
        exp_q.push_back('{cycle, 3, {31'd0, re}});
        exp_q.push_back('{cycle, 4, {31'd0, st}});
        exp_q.push_back('{cycle, 5, r0});
        exp_q.push_back('{cycle, 6, r1});
        tag++;
    endtask

    task automatic idle_step(input logic [31:0] r0, input logic [31:0] r1);
        drive(1'b0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        expect_out(0, 0, 0, 0, 0, r0, r1);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        mem[8'h10] = 32'h11;
        mem[8'h20] = 32'h22;
        mem[8'h40] = 32'hDEADBEEF;

        // Reset held with both lanes loading: nothing granted, no stall.
        drive(1'b1, 0, 1, 0, 0, 32'h10, 0, 1, 0, 0, 32'h20);
        expect_out(0, 0, 0, 0, 0, 0, 0);

        // Conflict of two loads, lane0 first.
        drive(1'b0, 0, 1, 0, 0, 32'h10, 0, 1, 0, 0, 32'h20);
        expect_out(32'h10, 0, 0, 1, 1, 0, 0);
        drive(1'b0, 0, 1, 0, 0, 32'h10, 0, 1, 0, 0, 32'h20);
        expect_out(32'h20, 0, 0, 1, 0, 32'h11, 0);
        // Back-to-back conflict: lane1 now has priority.
        drive(1'b0, 0, 1, 0, 0, 32'h40, 0, 1, 0, 0, 32'h10);
        expect_out(32'h10, 0, 0, 1, 1, 32'h11, 32'h22);
        drive(1'b0, 0, 1, 0, 0, 32'h40, 0, 1, 0, 0, 32'h10);
        expect_out(32'h40, 0, 0, 1, 0, 0, 32'h11);
        idle_step(32'hDEADBEEF, 32'h11);

        // Single lane0 load.
        drive(1'b0, 0, 1, 0, 0, 32'h40, 0, 0, 0, 0, 0);
        expect_out(32'h40, 0, 0, 1, 0, 0, 0);
        idle_step(32'hDEADBEEF, 0);

        // Same-address store/store: later grant's data persists.
        drive(1'b0, 1, 0, 32'h80, 32'hA, 0, 1, 0, 32'h80, 32'hB, 0);
        expect_out(32'h80, 32'hA, 1, 0, 1, 0, 0);
        drive(1'b0, 1, 0, 32'h80, 32'hA, 0, 1, 0, 32'h80, 32'hB, 0);
        expect_out(32'h80, 32'hB, 1, 0, 0, 0, 0);
        drive(1'b0, 0, 1, 0, 0, 32'h80, 0, 0, 0, 0, 0);
        expect_out(32'h80, 0, 0, 1, 0, 0, 0);
        idle_step(32'hB, 0);

        // Reset pulsed during SECOND.
        drive(1'b0, 0, 1, 0, 0, 32'h10, 0, 1, 0, 0, 32'h20);
        expect_out(32'h20, 0, 0, 1, 1, 0, 0);
        drive(1'b1, 0, 1, 0, 0, 32'h10, 0, 1, 0, 0, 32'h20);
        expect_out(0, 0, 0, 0, 0, 0, 0);
        drive(1'b0, 0, 1, 0, 0, 32'h10, 0, 1, 0, 0, 32'h20);
        expect_out(32'h10, 0, 0, 1, 1, 0, 0);
        drive(1'b0, 0, 1, 0, 0, 32'h10, 0, 1, 0, 0, 32'h20);
        expect_out(32'h20, 0, 0, 1, 0, 32'h11, 0);
        idle_step(32'h11, 32'h22);

        // Single lane1 store.
        drive(1'b0, 0, 0, 0, 0, 0, 1, 0, 32'h44, 32'h55, 0);
        expect_out(32'h44, 32'h55, 1, 0, 0, 0, 0);

        // Store and load on the same lane: store only.
        drive(1'b0, 1, 1, 32'h30, 32'h77, 32'h30, 0, 0, 0, 0, 0);
        expect_out(32'h30, 32'h77, 1, 0, 0, 0, 0);
        idle_step(0, 0);

        // Store (lane1, has priority) then load (lane0) to the same address.
        drive(1'b0, 0, 1, 0, 0, 32'h90, 1, 0, 32'h90, 32'h99, 0);
        expect_out(32'h90, 32'h99, 1, 0, 1, 0, 0);
        drive(1'b0, 0, 1, 0, 0, 32'h90, 1, 0, 32'h90, 32'h99, 0);
        expect_out(32'h90, 0, 0, 1, 0, 0, 0);
        idle_step(32'h99, 0);

        // Priority returned to lane0 after lane1 was served first.
        drive(1'b0, 0, 1, 0, 0, 32'h20, 0, 1, 0, 0, 32'h10);
        expect_out(32'h20, 0, 0, 1, 1, 0, 0);
        drive(1'b0, 0, 1, 0, 0, 32'h20, 0, 1, 0, 0, 32'h10);
        expect_out(32'h10, 0, 0, 1, 0, 32'h22, 0);
        idle_step(32'h22, 32'h11);

        for (int i = 0; i < 3 && exp_q.size() > 0; i++) @(posedge clk);
        @(negedge clk);
        #1;
        while (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_checks++;
            n_fail++;
            $display("FAIL unchecked_%s step %0d: never compared, required %h",
                     sig_name(e.sel), e.cyc, e.val);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
        $fatal(1, "watchdog");
    end

endmodule
